// File: rtl/boss_pkg.sv
// Shared types and defaults for the boss hit gate: FSM states, i-frame defaults
// and the hit-acceptance helper.
package boss_pkg;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        HIT      = 2'd1,
        COOLDOWN = 2'd2
    } boss_hit_state_t;

    localparam int BOSS_IFRAME_FRAMES = 30;
    localparam int BOSS_IFRAME_CNT_W  = 6;

    // Damage may only land during live play, on a living boss, outside a restart pulse.
    function automatic logic hit_gate_open(input logic [1:0] phase,
                                           input logic [6:0] hp,
                                           input logic       start);
        return (phase == 2'd1) && (hp != 7'd0) && !start;
    endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Single-bit rising-edge detector with a configurable reset value for the
// delayed copy, so a level already high at reset release can be masked.
module edge_rise_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise
);

    logic sig_q;

    // Delayed copy of the input level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise = sig_i & ~sig_q;

endmodule

// File: rtl/boss_hit_gate.sv
// Turns level collision flags into single-cycle damage pulses with a frame-based
// invulnerability window; the window exists only when BOSS_HIT_IFRAME_EN is defined.
module boss_hit_gate
    import boss_pkg::*;
#(
    parameter int IFRAME_FRAMES = BOSS_IFRAME_FRAMES,
    parameter int CNT_W         = BOSS_IFRAME_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_start,
    input  logic [1:0] game_active,
    input  logic       vsync,
    input  logic [6:0] boss_hp,
    input  logic       projectile_contact,
    input  logic       melee_contact,
    output logic       projectile_hit,
    output logic       melee_hit,
    output logic       boss_invuln
);

    logic proj_edge_s;
    logic melee_edge_s;
    logic tick_s;
    logic any_edge_s;
    logic gate_open_s;

    logic proj_hit_d,  proj_hit_q;
    logic melee_hit_d, melee_hit_q;
    logic invuln_d,    invuln_q;

    // Contacts reset high so a contact held through reset release is not a hit.
    edge_rise_det #(.RST_VAL(1'b1)) u_proj_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_i (projectile_contact),
        .rise  (proj_edge_s)
    );

    edge_rise_det #(.RST_VAL(1'b1)) u_melee_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_i (melee_contact),
        .rise  (melee_edge_s)
    );

    edge_rise_det #(.RST_VAL(1'b0)) u_vsync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_i (vsync),
        .rise  (tick_s)
    );

    assign any_edge_s  = proj_edge_s | melee_edge_s;
    assign gate_open_s = hit_gate_open(game_active, boss_hp, game_start);

`ifdef BOSS_HIT_IFRAME_EN
    localparam logic [CNT_W-1:0] IFRAME_LOAD = CNT_W'(IFRAME_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    boss_hit_state_t   state_d, state_q;
    logic [CNT_W-1:0]  cnt_d,   cnt_q;
    logic              abort_s;

    assign abort_s = game_start | (game_active != 2'd1);

    // Next-state, frame countdown and pulse selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        proj_hit_d  = 1'b0;
        melee_hit_d = 1'b0;
        if (abort_s) begin
            state_d = READY;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                READY: begin
                    if (gate_open_s && any_edge_s) begin
                        state_d     = HIT;
                        cnt_d       = IFRAME_LOAD;
                        melee_hit_d = melee_edge_s;
                        proj_hit_d  = proj_edge_s & ~melee_edge_s;
                    end else begin
                        state_d = READY;
                    end
                end
                HIT, COOLDOWN: begin
                    // A tick in the accept cycle never reaches here, so counting
                    // starts with the first tick seen in HIT.
                    if (tick_s) begin
                        if (cnt_q == CNT_ONE) begin
                            state_d = READY;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            state_d = COOLDOWN;
                            cnt_d   = cnt_q - CNT_ONE;
                        end
                    end else begin
                        state_d = COOLDOWN;
                    end
                end
                default: begin
                    state_d = READY;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
        invuln_d = (state_d != READY);
    end

    // FSM state and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= READY;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_cfg_s;

    assign unused_cfg_s = ^{tick_s, IFRAME_FRAMES[0], CNT_W[0]};

    // Always READY: every accepted edge pulses, melee first.
    always_comb begin
        melee_hit_d = gate_open_s & melee_edge_s;
        proj_hit_d  = gate_open_s & proj_edge_s & ~melee_edge_s;
        invuln_d    = 1'b0;
    end
`endif

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proj_hit_q  <= 1'b0;
            melee_hit_q <= 1'b0;
            invuln_q    <= 1'b0;
        end else begin
            proj_hit_q  <= proj_hit_d;
            melee_hit_q <= melee_hit_d;
            invuln_q    <= invuln_d;
        end
    end

    assign projectile_hit = proj_hit_q;
    assign melee_hit      = melee_hit_q;
    assign boss_invuln    = invuln_q;

endmodule

// File: doc/boss_hit_gate.md
# boss_hit_gate

Upstream neighbour of the boss HP stage. It converts raw, level-valued projectile and melee collision flags into clean single-cycle damage pulses: at most one pulse per contact and at most one pulse per cycle. After each accepted hit it holds the boss invulnerable for a fixed number of video frames. Its pulses drive the boss HP counter's `projectile_hit`/`melee_hit` inputs, and its `boss_invuln` level drives sprite flashing.

## Interface
Parameters:
- `IFRAME_FRAMES`, default 30: invulnerability length in frames after an accepted hit; legal range 1..63.
- `CNT_W`, default 6: cooldown counter width; must satisfy `IFRAME_FRAMES < 2**CNT_W`.

Ports:
- `clk` in 1: system (pixel) clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `game_start` in 1: one-cycle pulse; restarts the gate.
- `game_active` in 2: game phase; hits are accepted only when it equals 1.
- `vsync` in 1: VGA vsync; its rising edge is the frame tick.
- `boss_hp` in 7: current boss HP; hits are blocked while it is 0.
- `projectile_contact` in 1: level; a projectile overlaps the boss.
- `melee_contact` in 1: level; the melee swing overlaps the boss.
- `projectile_hit` out 1: registered one-cycle damage pulse.
- `melee_hit` out 1: registered one-cycle damage pulse.
- `boss_invuln` out 1: registered; high while in cooldown.

## Operation
- **Rising-edge detection.** Each contact input is registered into `*_q`, and `edge = contact & ~contact_q`. Both `*_q` registers reset to 1, so a contact already high when reset is released does not count as a hit.
- **Frame tick.** `tick = vsync & ~vsync_q`, with `vsync_q` resetting to 0.
- **Accept condition.** A cycle accepts a hit when all of the following hold: state READY, `game_active == 1`, `boss_hp != 0`, `game_start == 0`, and at least one edge is present.
- **Simultaneous edges.** Melee has priority: only `melee_hit` pulses and the projectile edge is discarded. This guarantees exactly one HP decrement.
- **Edges outside READY.** An edge that arrives while the gate is not in READY is discarded, not queued. A contact still held when cooldown ends does not retrigger; a new rising edge is required.

State machine:
- **READY.** On accept, go to HIT and load `cnt = IFRAME_FRAMES`.
- **HIT.** Lasts exactly one cycle; then go to COOLDOWN.
- **COOLDOWN.** On each `tick`, decrement `cnt`. On a `tick` with `cnt == 1`, go to READY.
- **Abort.** From any state, `game_start`, or `game_active != 1`, forces READY, `cnt = 0`, and all outputs low on the next cycle.

Reset values: state READY, `cnt` 0, and `projectile_hit`, `melee_hit` and `boss_invuln` all 0.

## Timing
- **Hit latency.** If the contact is sampled high at clock edge N (with `_q` low), the hit pulse is high for the single cycle following edge N. `boss_invuln` rises in that same cycle.
- **Invulnerability window.** `boss_invuln` stays high through HIT and COOLDOWN. It falls in the cycle after the `IFRAME_FRAMES`-th tick following the hit.
- **Earliest next hit.** The next acceptable edge can be sampled in the cycle after `boss_invuln` falls.
- **Tick coinciding with acceptance.** A `tick` in the accept cycle is ignored. Counting starts with the first tick seen in HIT or COOLDOWN.
- **Reset mid-operation.** Asserting `rst_n` low clears every output immediately (asynchronously), regardless of state.

## Configuration
- `BOSS_HIT_IFRAME_EN` defined: the full READY/HIT/COOLDOWN behaviour described above.
- Undefined: there is no cooldown and no counter; `boss_invuln` is tied to 0. Every accepted edge produces a pulse, and the gate is always READY. Edge detection, melee priority, and gating by `game_active`/`boss_hp`/`game_start` remain unchanged.

## Structure
- `boss_pkg`:
  - enum `boss_hit_state_t` (READY, HIT, COOLDOWN);
  - constant `BOSS_IFRAME_FRAMES = 30`;
  - constant `BOSS_IFRAME_CNT_W = 6`.
- Sub-module `edge_rise_det`: parameterised reset value of `_q`; output `rise`. Instantiate it three times: projectile, melee and vsync.

## Test plan
- **Reset release with contact high.** Release `rst_n` with `projectile_contact` already high, `game_active = 1`, `boss_hp = 100` → no pulse. Drop and re-raise the contact → `projectile_hit` is high for exactly 1 cycle, in the cycle after the contact is sampled high.
- **Simultaneous edges.** Melee and projectile edges in the same cycle → `melee_hit` = 1 and `projectile_hit` = 0 in that cycle, with exactly one pulse total.
- **Cooldown length.** `IFRAME_FRAMES = 3`; hit, then 5 contact edges during 2 vsync ticks → no further pulses. After the 3rd tick, `boss_invuln` falls; the next edge produces a pulse.
- **Gating.** Edges with `game_active = 2`, or with `boss_hp = 0` → no pulses and `boss_invuln` stays 0.
- **Abort.** `game_start` pulse mid-cooldown → `boss_invuln` is 0 the next cycle, and an immediate new edge is accepted.
- **Macro off.** With `BOSS_HIT_IFRAME_EN` undefined, 4 edges 10 cycles apart → 4 pulses, and `boss_invuln` is constantly 0.
